multdiv: RTL and testbench
==========================

MULTDIV -- requirements
Module: multdiv

Interface
REQ-001 Port clock  input  1  sole clock; all state updates on rising edge.
REQ-002 Port reset  input  1  synchronous, active-high reset.
REQ-003 Port data_operandA  input  32  signed operand A (multiplicand / dividend), two's complement.
REQ-004 Port data_operandB  input  32  signed operand B (multiplier / divisor), two's complement.
REQ-005 Port ctrl_MULT  input  1  single-cycle start pulse for A*B.
REQ-006 Port ctrl_DIV  input  1  single-cycle start pulse for A/B.
REQ-007 Port data_result  output  32  product low word or quotient.
REQ-008 Port data_exception  output  1  overflow / divide-by-zero flag, valid with data_result.
REQ-009 Port data_resultRDY  output  1  one-cycle result-valid strobe.
REQ-010 Port busy  output  1  operation in progress; the execute-stage stall source.

Function
REQ-011 FSM states IDLE, MULT, DIV, DONE; reset enters IDLE.
REQ-012 Start sampled at rising edge k (ctrl_MULT or ctrl_DIV high) latches data_operandA/B at that edge and enters MULT or DIV; operands are not resampled afterwards.
REQ-013 ctrl_MULT and ctrl_DIV both high at the same edge -> MULT; ctrl_DIV ignored.
REQ-014 Iterative datapath, one bit per cycle, 32 iteration cycles; no combinational 32x32 multiplier or divider.
REQ-015 Fixed latency: for start at edge k, data_resultRDY high exactly during the cycle after edge k+33 (DONE state), for both MULT and DIV, including exception cases.
REQ-016 busy high from the cycle after edge k through the cycle after edge k+32; low in the DONE cycle and in IDLE.
REQ-017 DONE returns to IDLE on the next edge unless a new start is sampled, in which case REQ-012 applies.
REQ-018 data_result and data_exception update only when entering DONE; held stable until the next DONE or reset.
REQ-019 MULT: data_result = low 32 bits of signed 64-bit product A*B.
REQ-020 MULT exception = 1 iff the 64-bit product's upper 33 bits are not all equal, i.e. the product does not fit in signed 32 bits.
REQ-021 DIV: signed quotient truncated toward zero; sign = sign(A) XOR sign(B); remainder discarded.
REQ-022 DIV by B=0: data_result = 0, exception = 1.
REQ-023 DIV A=0x80000000, B=0xFFFFFFFF: data_result = 0x80000000, exception = 1.
REQ-024 Otherwise DIV exception = 0.
REQ-025 Start sampled while busy: current operation abandoned without an RDY strobe; new operation restarts per REQ-012 with its own full latency.
REQ-026 Start pulse held high for several cycles: each sampled edge restarts per REQ-025; only the last start produces an RDY strobe.

Reset
REQ-027 Reset sampled high -> next cycle: state IDLE, data_result = 0, data_exception = 0, data_resultRDY = 0, busy = 0, iteration counter = 0.
REQ-028 Reset dominates a start pulse at the same edge; the start is dropped.
REQ-029 Reset mid-operation aborts it; no RDY strobe is produced for it.
REQ-030 No output depends combinationally on the operand or ctrl inputs; all outputs are registered.

Verification
REQ-031 MULT A=7, B=-6 at edge k -> busy high during cycles k+1..k+33; RDY high only in the cycle after edge k+33 with result 0xFFFFFFD6, exc 0.
REQ-032 MULT A=0x00010000, B=0x00010000 -> result 0x00000000, exc 1; MULT 0x7FFFFFFF*1 -> 0x7FFFFFFF, exc 0.
REQ-033 DIV A=-7, B=2 -> result 0xFFFFFFFD, exc 0; DIV 100/0 -> result 0, exc 1, same latency.
REQ-034 DIV 0x80000000 / 0xFFFFFFFF -> result 0x80000000, exc 1; DIV 0x80000000/1 -> 0x80000000, exc 0.
REQ-035 MULT start, then DIV 20/4 start 10 cycles later -> single RDY strobe 33 cycles after the DIV start with result 5; ctrl_MULT and ctrl_DIV together -> multiply result.
REQ-036 Reset at cycle 15 of a MULT -> no RDY strobe; all outputs 0 the cycle after reset; a subsequent MULT 3*3 -> result 9.

Source files
------------

// File: rtl/multdiv_if.sv
// multdiv_if: operand/control/result bundle for the iterative multiply/divide unit.
//   data_operandA/B : signed 32-bit operands (master -> slave)
//   ctrl_MULT/DIV   : single-cycle start pulses (master -> slave)
//   data_result     : product low word or quotient (slave -> master)
//   data_exception  : overflow / divide-by-zero flag, valid with data_result
//   data_resultRDY  : one-cycle result-valid strobe
//   busy            : operation in progress (stall source)
interface multdiv_if;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    modport master (
        output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        input  data_result, data_exception, data_resultRDY, busy
    );

    modport slave (
        input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        output data_result, data_exception, data_resultRDY, busy
    );
endinterface

// File: rtl/multdiv.sv
// multdiv: iterative signed 32x32 multiply (low word) and 32/32 divide (quotient).
// One bit per cycle, fixed latency: start at edge k -> result strobe in the
// cycle after edge k+33. A new start at any time restarts the unit.
//   clock : rising-edge clock
//   reset : synchronous active-high reset
//   bus   : multdiv_if.slave (operands, start pulses, registered results)
module multdiv (
    input  logic      clock,
    input  logic      reset,
    multdiv_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;

    state_t      state;
    logic [5:0]  count;
    logic [63:0] acc;       // MULT: running product; DIV: {remainder, quotient}
    logic [31:0] mag;       // |multiplicand| or |divisor|
    logic        neg;       // result sign
    logic        dzero;     // divisor was zero
    logic        dovf;      // 0x80000000 / -1
    logic [31:0] result_q;
    logic        exc_q;
    logic        rdy_q;
    logic        busy_q;

    logic [31:0] abs_a, abs_b;
    logic [32:0] mul_sum;
    logic [32:0] div_shift, div_diff;
    logic        div_ge;
    logic [63:0] mul_next, div_next;
    logic [63:0] prod_s;
    logic [31:0] quo_s;
    logic        mul_exc;
    logic        start;

    always_comb begin
        start   = bus.ctrl_MULT | bus.ctrl_DIV;
        abs_a   = bus.data_operandA[31] ? (32'd0 - bus.data_operandA) : bus.data_operandA;
        abs_b   = bus.data_operandB[31] ? (32'd0 - bus.data_operandB) : bus.data_operandB;

        // Shift-add: add multiplicand to the high half when the current
        // multiplier bit (acc[0]) is set, then shift the whole thing right.
        mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, mag} : 33'd0);
        mul_next = {mul_sum, acc[31:1]};

        // Restoring division: remainder stays below the divisor (<= 2^31),
        // so the 33-bit difference sign bit is a valid compare result.
        div_shift = {acc[63:32], acc[31]};
        div_diff  = div_shift - {1'b0, mag};
        div_ge    = ~div_diff[32];
        div_next  = {(div_ge ? div_diff[31:0] : div_shift[31:0]), acc[30:0], div_ge};

        prod_s  = neg ? (64'd0 - acc) : acc;
        quo_s   = neg ? (32'd0 - acc[31:0]) : acc[31:0];
        // Product fits in signed 32 bits only if bits 63..31 are all equal.
        mul_exc = ~((&prod_s[63:31]) | ~(|prod_s[63:31]));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            count    <= '0;
            acc      <= '0;
            mag      <= '0;
            neg      <= 1'b0;
            dzero    <= 1'b0;
            dovf     <= 1'b0;
            result_q <= '0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else if (start) begin
            // Restart from any state; MULT wins when both pulses arrive together.
            count  <= '0;
            neg    <= bus.data_operandA[31] ^ bus.data_operandB[31];
            dzero  <= (bus.data_operandB == '0);
            dovf   <= (bus.data_operandA == 32'h8000_0000) && (bus.data_operandB == '1);
            rdy_q  <= 1'b0;
            busy_q <= 1'b1;
            if (bus.ctrl_MULT) begin
                state <= MULT;
                acc   <= {32'd0, abs_b};
                mag   <= abs_a;
            end else begin
                state <= DIV;
                acc   <= {32'd0, abs_a};
                mag   <= abs_b;
            end
        end else begin
            case (state)
                MULT, DIV: begin
                    if (count != 6'd32) begin
                        count <= count + 6'd1;
                        acc   <= (state == MULT) ? mul_next : div_next;
                    end else begin
                        state  <= DONE;
                        busy_q <= 1'b0;
                        rdy_q  <= 1'b1;
                        if (state == MULT) begin
                            result_q <= prod_s[31:0];
                            exc_q    <= mul_exc;
                        end else if (dzero) begin
                            result_q <= '0;
                            exc_q    <= 1'b1;
                        end else begin
                            result_q <= quo_s;
                            exc_q    <= dovf;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    rdy_q <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    rdy_q  <= 1'b0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.data_result    = result_q;
    assign bus.data_exception = exc_q;
    assign bus.data_resultRDY = rdy_q;
    assign bus.busy           = busy_q;
endmodule

// File: tb/tb_multdiv.sv
// tb_multdiv: directed self-checking bench for multdiv.
module tb_multdiv;
    logic clock;
    logic reset;
    int   tests;
    int   fails;

    multdiv_if bus ();

    multdiv dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Called at a negedge: drives a start for the next rising edge, returns
    // at the negedge of the cycle following that edge (observation index 0).
    task automatic start_op(input logic m, input logic d,
                            input logic [31:0] a, input logic [31:0] b);
        bus.ctrl_MULT     = m;
        bus.ctrl_DIV      = d;
        bus.data_operandA = a;
        bus.data_operandB = b;
        @(negedge clock);
        bus.ctrl_MULT = 1'b0;
        bus.ctrl_DIV  = 1'b0;
    endtask

    // Records what the DUT does over n cycles; comparisons are left to callers.
    task automatic observe(input int n, output int n_rdy, output int rdy_at,
                           output int busy_first, output int busy_last,
                           output logic [31:0] res, output logic exc);
        n_rdy = 0; rdy_at = -1; busy_first = -1; busy_last = -1;
        res = '0; exc = 1'b0;
        for (int j = 0; j < n; j++) begin
            if (bus.busy) begin
                if (busy_first < 0) busy_first = j;
                busy_last = j;
            end
            if (bus.data_resultRDY) begin
                n_rdy++;
                if (rdy_at < 0) rdy_at = j;
                res = bus.data_result;
                exc = bus.data_exception;
            end
            @(negedge clock);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.ctrl_MULT = 1'b0; bus.ctrl_DIV = 1'b0;
        bus.data_operandA = '0; bus.data_operandB = '0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        tests++;
        if (bus.data_result !== 32'd0 || bus.data_exception !== 1'b0 ||
            bus.data_resultRDY !== 1'b0 || bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs: got res=%h exc=%b rdy=%b busy=%b, want all 0",
                     bus.data_result, bus.data_exception, bus.data_resultRDY, bus.busy);
        end
    endtask

    task automatic test_vectors();
        logic        vm  [10] = '{1, 1, 1, 1, 0, 0, 0, 0, 1, 1};
        logic [31:0] va  [10] = '{32'd7, 32'h0001_0000, 32'h7FFF_FFFF, 32'h8000_0000,
                                  32'hFFFF_FFF9, 32'd100, 32'h8000_0000, 32'h8000_0000,
                                  32'hFFFF_FFF8, 32'h0000_FFFF};
        logic [31:0] vb  [10] = '{32'hFFFF_FFFA, 32'h0001_0000, 32'd1, 32'hFFFF_FFFF,
                                  32'd2, 32'd0, 32'hFFFF_FFFF, 32'd1,
                                  32'hFFFF_FFF8, 32'h0001_0001};
        logic [31:0] vr  [10] = '{32'hFFFF_FFD6, 32'h0000_0000, 32'h7FFF_FFFF, 32'h8000_0000,
                                  32'hFFFF_FFFD, 32'h0000_0000, 32'h8000_0000, 32'h8000_0000,
                                  32'd64, 32'hFFFF_FFFF};
        logic        ve  [10] = '{0, 1, 0, 1, 0, 1, 1, 0, 0, 1};
        int n_rdy, rdy_at, bf, bl;
        logic [31:0] res;
        logic exc;
        for (int i = 0; i < 10; i++) begin
            start_op(vm[i], !vm[i], va[i], vb[i]);
            observe(35, n_rdy, rdy_at, bf, bl, res, exc);
            tests++;
            if (rdy_at !== 33 || n_rdy !== 1) begin
                fails++;
                $display("FAIL vec%0d_rdy: got first=%0d count=%0d, want first=33 count=1",
                         i, rdy_at, n_rdy);
            end
            tests++;
            if (bf !== 0 || bl !== 32) begin
                fails++;
                $display("FAIL vec%0d_busy: got %0d..%0d, want 0..32", i, bf, bl);
            end
            tests++;
            if (res !== vr[i] || exc !== ve[i]) begin
                fails++;
                $display("FAIL vec%0d_result: got %h exc=%b, want %h exc=%b",
                         i, res, exc, vr[i], ve[i]);
            end
            tests++;
            if (bus.data_result !== vr[i] || bus.data_exception !== ve[i]) begin
                fails++;
                $display("FAIL vec%0d_hold: got %h exc=%b, want %h exc=%b",
                         i, bus.data_result, bus.data_exception, vr[i], ve[i]);
            end
        end
    endtask

    task automatic test_restart();
        int n_rdy, rdy_at, bf, bl;
        logic [31:0] res;
        logic exc;
        start_op(1'b1, 1'b0, 32'd1000, 32'd1000);
        observe(10, n_rdy, rdy_at, bf, bl, res, exc);
        start_op(1'b0, 1'b1, 32'd20, 32'd4);
        tests++;
        if (n_rdy !== 0) begin
            fails++;
            $display("FAIL restart_abandon: got %0d strobes, want 0", n_rdy);
        end
        observe(40, n_rdy, rdy_at, bf, bl, res, exc);
        tests++;
        if (n_rdy !== 1 || rdy_at !== 33 || res !== 32'd5 || exc !== 1'b0) begin
            fails++;
            $display("FAIL restart_div: got count=%0d at=%0d res=%h exc=%b, want 1 at 33 res=00000005 exc=0",
                     n_rdy, rdy_at, res, exc);
        end
    endtask

    task automatic test_both_ctrl();
        int n_rdy, rdy_at, bf, bl;
        logic [31:0] res;
        logic exc;
        start_op(1'b1, 1'b1, 32'd6, 32'd3);
        observe(36, n_rdy, rdy_at, bf, bl, res, exc);
        tests++;
        if (n_rdy !== 1 || rdy_at !== 33 || res !== 32'd18 || exc !== 1'b0) begin
            fails++;
            $display("FAIL both_ctrl: got count=%0d at=%0d res=%h exc=%b, want 1 at 33 res=00000012 exc=0",
                     n_rdy, rdy_at, res, exc);
        end
    endtask

    task automatic test_held_start();
        int n_rdy, rdy_at, bf, bl;
        logic [31:0] res;
        logic exc;
        bus.ctrl_MULT = 1'b1; bus.data_operandA = 32'd2; bus.data_operandB = 32'd5;
        repeat (3) @(negedge clock);
        bus.ctrl_MULT = 1'b0;
        observe(36, n_rdy, rdy_at, bf, bl, res, exc);
        tests++;
        if (n_rdy !== 1 || rdy_at !== 33 || res !== 32'd10) begin
            fails++;
            $display("FAIL held_start: got count=%0d at=%0d res=%h, want 1 at 33 res=0000000a",
                     n_rdy, rdy_at, res);
        end
    endtask

    task automatic test_reset_mid_op();
        int n_rdy, rdy_at, bf, bl;
        logic [31:0] res;
        logic exc;
        start_op(1'b1, 1'b0, 32'd11, 32'd13);
        observe(15, n_rdy, rdy_at, bf, bl, res, exc);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        tests++;
        if (bus.data_result !== 32'd0 || bus.data_exception !== 1'b0 ||
            bus.data_resultRDY !== 1'b0 || bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_op_outputs: got res=%h exc=%b rdy=%b busy=%b, want all 0",
                     bus.data_result, bus.data_exception, bus.data_resultRDY, bus.busy);
        end
        observe(40, n_rdy, rdy_at, bf, bl, res, exc);
        tests++;
        if (n_rdy !== 0 || bf !== -1) begin
            fails++;
            $display("FAIL reset_mid_op_abort: got %0d strobes busy_first=%0d, want 0 and -1",
                     n_rdy, bf);
        end
        start_op(1'b1, 1'b0, 32'd3, 32'd3);
        observe(36, n_rdy, rdy_at, bf, bl, res, exc);
        tests++;
        if (n_rdy !== 1 || rdy_at !== 33 || res !== 32'd9 || exc !== 1'b0) begin
            fails++;
            $display("FAIL reset_then_mult: got count=%0d at=%0d res=%h exc=%b, want 1 at 33 res=00000009 exc=0",
                     n_rdy, rdy_at, res, exc);
        end
    endtask

    task automatic test_reset_vs_start();
        int n_rdy, rdy_at, bf, bl;
        logic [31:0] res;
        logic exc;
        reset = 1'b1;
        start_op(1'b1, 1'b0, 32'd4, 32'd4);
        reset = 1'b0;
        observe(40, n_rdy, rdy_at, bf, bl, res, exc);
        tests++;
        if (n_rdy !== 0 || bf !== -1 || bus.data_result !== 32'd0) begin
            fails++;
            $display("FAIL reset_vs_start: got %0d strobes busy_first=%0d res=%h, want 0, -1, 00000000",
                     n_rdy, bf, bus.data_result);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        @(negedge clock);
        test_reset();
        test_vectors();
        test_restart();
        test_both_ctrl();
        test_held_start();
        test_reset_mid_op();
        test_reset_vs_start();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
